// File: rtl/oam_dma_ctrl_pkg.sv
// Shared NES bus definitions: bus widths, register addresses used for
// PPU/APU decode, and the sprite-DMA state encoding.
package oam_dma_ctrl_pkg;

  localparam int NES_ADDR_WIDTH = 16;
  localparam int NES_REG_WIDTH  = 8;

  localparam logic [15:0] NES_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] NES_OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_DUMMY = 3'd2,
    ST_ALIGN = 3'd3,
    ST_READ  = 3'd4,
    ST_WRITE = 3'd5
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA controller and CPU bus arbiter. A CPU write to the trigger
// register halts the CPU via rdy, then 256 bytes of page $XX00-$XXFF are
// copied to the OAM data port before the bus is handed back.
// Optional feature: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle when
// the DMA would otherwise start its reads on the wrong cycle parity.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus passed through from CPU, waiting for trigger write
// HALT   | rdy low, CPU writes still pass through, wait for a CPU read
// DUMMY  | stalled CPU read repeats on the bus (one cycle)
// ALIGN  | idle bus cycle owned by DMA to fix read/write parity
// READ   | DMA reads {page, idx}
// WRITE  | DMA writes the fetched byte to the OAM data port
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = NES_ADDR_WIDTH,
  parameter int                    REG_WIDTH     = NES_REG_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = NES_DMA_REG_ADDR,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = NES_OAM_DATA_ADDR
) (
  input  logic                  phi0,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_a,
  input  logic [REG_WIDTH-1:0]  cpu_d_out,
  input  logic                  cpu_r_w_n,
  input  logic [REG_WIDTH-1:0]  bus_d_in,
  output logic                  rdy,
  output logic [ADDR_WIDTH-1:0] bus_a,
  output logic [REG_WIDTH-1:0]  bus_d_out,
  output logic                  bus_r_w_n,
  output logic                  dma_busy
);

  dma_state_t           state;
  logic [REG_WIDTH-1:0] page;
  logic [7:0]           idx;
  logic [REG_WIDTH-1:0] data;
`ifdef OAM_DMA_ALIGN_EN
  // Free-running cycle parity; only the aligned build consumes it.
  logic                 parity;
`endif

  logic trig;
  assign trig = (cpu_a == DMA_REG_ADDR) && !cpu_r_w_n;

  // Sequencer: state, transfer registers and the registered rdy/dma_busy.
  always_ff @(posedge phi0) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      page     <= '0;
      idx      <= '0;
      data     <= '0;
      rdy      <= 1'b1;
      dma_busy <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      parity   <= 1'b0;
`endif
    end else begin
`ifdef OAM_DMA_ALIGN_EN
      parity <= ~parity;
`endif
      case (state)
        ST_IDLE: begin
          if (trig) begin
            page     <= cpu_d_out;
            idx      <= '0;
            state    <= ST_HALT;
            rdy      <= 1'b0;
            dma_busy <= 1'b1;
          end
        end
        ST_HALT: begin
          if (cpu_r_w_n) state <= ST_DUMMY;
        end
        ST_DUMMY: begin
`ifdef OAM_DMA_ALIGN_EN
          state <= parity ? ST_ALIGN : ST_READ;
`else
          state <= ST_READ;
`endif
        end
        ST_ALIGN: state <= ST_READ;
        ST_READ: begin
          data  <= bus_d_in;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (idx == 8'hFF) begin
            state    <= ST_IDLE;
            rdy      <= 1'b1;
            dma_busy <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= ST_READ;
          end
        end
        default: begin
          state    <= ST_IDLE;
          rdy      <= 1'b1;
          dma_busy <= 1'b0;
        end
      endcase
    end
  end

  // Bus arbitration: CPU passes through except where the DMA owns the bus.
  always_comb begin
    bus_a     = cpu_a;
    bus_d_out = cpu_d_out;
    bus_r_w_n = cpu_r_w_n;
    case (state)
      ST_ALIGN: bus_r_w_n = 1'b1;
      ST_READ: begin
        bus_a     = ADDR_WIDTH'({page, idx});
        bus_r_w_n = 1'b1;
      end
      ST_WRITE: begin
        bus_a     = OAM_DATA_ADDR;
        bus_d_out = data;
        bus_r_w_n = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: reset, plain transfer, HALT extension,
// parity alignment (macro dependent), top page, and reset mid-transfer.
module tb_oam_dma_ctrl;

  logic        phi0 = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d_out;
  logic        cpu_r_w_n;
  logic [7:0]  bus_d_in;
  logic        rdy;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_out;
  logic        bus_r_w_n;
  logic        dma_busy;

  int checks = 0;
  int errors = 0;

  oam_dma_ctrl dut (
    .phi0      (phi0),
    .reset_n   (reset_n),
    .cpu_a     (cpu_a),
    .cpu_d_out (cpu_d_out),
    .cpu_r_w_n (cpu_r_w_n),
    .bus_d_in  (bus_d_in),
    .rdy       (rdy),
    .bus_a     (bus_a),
    .bus_d_out (bus_d_out),
    .bus_r_w_n (bus_r_w_n),
    .dma_busy  (dma_busy)
  );

  always #5 phi0 = ~phi0;

  // Memory contents as a pure function of address.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ 8'h5A;
  endfunction

  assign bus_d_in = bus_r_w_n ? mem_f(bus_a) : 8'h00;

  // Cycle counter and reference parity model.
  int   cyc = 0;
  logic tb_par = 1'b0;
  always @(posedge phi0) begin
    cyc    <= cyc + 1;
    tb_par <= reset_n ? ~tb_par : 1'b0;
  end

  // Bus monitor, sampled mid-cycle.
  logic [15:0] rd_addr [2048];
  logic        rd_par  [2048];
  logic [15:0] wr_addr [2048];
  logic [7:0]  wr_data [2048];
  int rd_n = 0, wr_n = 0, low_n = 0, bsy_bad = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0;

  always @(negedge phi0) begin
    if (rdy === 1'b0) low_n <= low_n + 1;
    if (dma_busy !== ~rdy) bsy_bad <= bsy_bad + 1;
    if (dma_busy === 1'b1 && bus_r_w_n === 1'b1 && bus_a !== cpu_a) begin
      if (rd_n < 2048) begin
        rd_addr[rd_n] <= bus_a;
        rd_par[rd_n]  <= tb_par;
      end
      rd_n <= rd_n + 1;
    end
    if (dma_busy === 1'b1 && bus_r_w_n === 1'b0 && cpu_r_w_n === 1'b1) begin
      if (wr_n < 2048) begin
        wr_addr[wr_n] <= bus_a;
        wr_data[wr_n] <= bus_d_out;
      end
      if (wr_n == 0 || first_wr_cyc < 0) first_wr_cyc <= cyc;
      last_wr_cyc <= cyc;
      wr_n <= wr_n + 1;
    end
  end

  int e0_cyc, rise_cyc, base_low, base_rd, base_wr, base_bsy;
  int first_wr_req;

  task automatic tick();
    @(posedge phi0);
    #1;
  endtask

  task automatic cpu_idle_read();
    cpu_a     = 16'h8000;
    cpu_d_out = 8'h00;
    cpu_r_w_n = 1'b1;
  endtask

  task automatic do_trigger(input logic [7:0] pg);
    cpu_a     = 16'h4014;
    cpu_d_out = pg;
    cpu_r_w_n = 1'b0;
    base_low  = low_n;
    base_rd   = rd_n;
    base_wr   = wr_n;
    base_bsy  = bsy_bad;
    tick();
    e0_cyc = cyc;
  endtask

  // Feeds CPU reads until rdy returns; records the cycle it rose.
  task automatic wait_done(output bit timeout);
    cpu_idle_read();
    timeout = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (rdy === 1'b1) begin
        timeout  = 1'b0;
        rise_cyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_idle_read();
    tick();
    tick();
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    checks++;
    if (dma_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", dma_busy); end
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [15:0] addrs [4];
      addrs = '{16'h0000, 16'h1234, 16'hFFFF, 16'h4013};
      cpu_a = addrs[i];
      cpu_r_w_n = 1'b1;
      #1;
      checks++;
      if (bus_a !== addrs[i] || bus_r_w_n !== 1'b1)
        begin errors++; $display("FAIL idle_passthru: bus_a=%h rw=%b want %h rw=1", bus_a, bus_r_w_n, addrs[i]); end
      tick();
      checks++;
      if (rdy !== 1'b1 || dma_busy !== 1'b0)
        begin errors++; $display("FAIL idle_rdy: rdy=%b busy=%b want 1/0", rdy, dma_busy); end
    end
  endtask

  task automatic test_transfer();
    bit to;
    int bad;
    cpu_idle_read();
    tick();
    do_trigger(8'h02);
    checks++;
    if (rdy !== 1'b0 || dma_busy !== 1'b1)
      begin errors++; $display("FAIL xfer_start: rdy=%b busy=%b want 0/1", rdy, dma_busy); end
    wait_done(to);
    checks++;
    if (to) begin errors++; $display("FAIL xfer_timeout: rdy never returned"); end
    checks++;
    if (low_n - base_low != 514) begin errors++; $display("FAIL xfer_len: got %0d want 514", low_n - base_low); end
    checks++;
    if (wr_n - base_wr != 256 || rd_n - base_rd != 256)
      begin errors++; $display("FAIL xfer_count: wr=%0d rd=%0d want 256/256", wr_n - base_wr, rd_n - base_rd); end
    checks++;
    if (first_wr_req - e0_cyc != 3)
      begin errors++; $display("FAIL xfer_first_wr: cycle %0d after E0 want 4", first_wr_req - e0_cyc + 1); end
    checks++;
    if (rise_cyc != last_wr_cyc + 1)
      begin errors++; $display("FAIL xfer_rdy_rise: got %0d want %0d", rise_cyc, last_wr_cyc + 1); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] ea;
      ea = 16'h0200 + 16'(i);
      if (rd_addr[base_rd+i] !== ea || wr_addr[base_wr+i] !== 16'h2004 || wr_data[base_wr+i] !== mem_f(ea)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL xfer_bytes: %0d bad of 256 want 0", bad); end
    checks++;
    if (bsy_bad != base_bsy) begin errors++; $display("FAIL xfer_busy_track: %0d cycles busy!=~rdy want 0", bsy_bad - base_bsy); end
  endtask

  task automatic test_halt_writes();
    bit to;
    int bad;
    cpu_idle_read();
    tick();
    do_trigger(8'h02);
    cpu_a = 16'h4014; cpu_d_out = 8'h07; cpu_r_w_n = 1'b0;
    #1;
    checks++;
    if (bus_a !== 16'h4014 || bus_d_out !== 8'h07 || bus_r_w_n !== 1'b0 || rdy !== 1'b0)
      begin errors++; $display("FAIL halt_wr1: a=%h d=%h rw=%b rdy=%b want 4014/07/0/0", bus_a, bus_d_out, bus_r_w_n, rdy); end
    tick();
    cpu_a = 16'h0300; cpu_d_out = 8'h3C; cpu_r_w_n = 1'b0;
    #1;
    checks++;
    if (bus_a !== 16'h0300 || bus_d_out !== 8'h3C || bus_r_w_n !== 1'b0 || rdy !== 1'b0)
      begin errors++; $display("FAIL halt_wr2: a=%h d=%h rw=%b rdy=%b want 0300/3c/0/0", bus_a, bus_d_out, bus_r_w_n, rdy); end
    tick();
    wait_done(to);
    checks++;
    if (to || low_n - base_low != 516)
      begin errors++; $display("FAIL halt_len: got %0d want 516", low_n - base_low); end
    checks++;
    if (first_wr_req - e0_cyc != 5)
      begin errors++; $display("FAIL halt_first_wr: offset %0d want 5", first_wr_req - e0_cyc); end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (wr_data[base_wr+i] !== mem_f(16'h0200 + 16'(i))) bad++;
    checks++;
    if (bad != 0 || wr_n - base_wr != 256)
      begin errors++; $display("FAIL halt_page_kept: %0d bad, %0d writes want 0/256", bad, wr_n - base_wr); end
  endtask

  task automatic test_align();
    bit to;
    logic par0;
    int exp_len, bad;
    par0 = 1'b0;
    for (int want = 0; want < 2; want++) begin
      cpu_idle_read();
      tick();
      if (tb_par !== 1'(want)) tick();
      do_trigger(8'h03);
      wait_done(to);
`ifdef OAM_DMA_ALIGN_EN
      exp_len = 514 + want;
`else
      exp_len = 514;
`endif
      checks++;
      if (to || low_n - base_low != exp_len)
        begin errors++; $display("FAIL align_len_p%0d: got %0d want %0d", want, low_n - base_low, exp_len); end
      checks++;
      if (wr_n - base_wr != 256 || wr_data[base_wr+255] !== mem_f(16'h03FF))
        begin errors++; $display("FAIL align_data_p%0d: %0d writes last %h want 256 %h", want, wr_n - base_wr, wr_data[base_wr+255], mem_f(16'h03FF)); end
`ifdef OAM_DMA_ALIGN_EN
      bad = 0;
      for (int i = 1; i < 256; i++) if (rd_par[base_rd+i] !== rd_par[base_rd]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL align_read_par_p%0d: %0d reads off parity want 0", want, bad); end
      if (want == 0) par0 = rd_par[base_rd];
      else begin
        checks++;
        if (rd_par[base_rd] !== par0)
          begin errors++; $display("FAIL align_par_runs: got %b want %b", rd_par[base_rd], par0); end
      end
`else
      bad = 0;
      if (want == 1) par0 = 1'b1;
`endif
    end
  endtask

  task automatic test_page_ff();
    bit to;
    int outside;
    cpu_idle_read();
    tick();
    do_trigger(8'hFF);
    wait_done(to);
    checks++;
    if (to || rd_n - base_rd != 256)
      begin errors++; $display("FAIL pff_reads: got %0d want 256", rd_n - base_rd); end
    checks++;
    if (rd_addr[base_rd] !== 16'hFF00 || rd_addr[base_rd+255] !== 16'hFFFF)
      begin errors++; $display("FAIL pff_range: %h..%h want ff00..ffff", rd_addr[base_rd], rd_addr[base_rd+255]); end
    outside = 0;
    for (int i = 0; i < 256; i++) if (rd_addr[base_rd+i][15:8] !== 8'hFF) outside++;
    checks++;
    if (outside != 0) begin errors++; $display("FAIL pff_wrap: %0d reads outside page want 0", outside); end
    checks++;
    if (wr_addr[base_wr+255] !== 16'h2004 || wr_data[base_wr+255] !== mem_f(16'hFFFF))
      begin errors++; $display("FAIL pff_last_wr: a=%h d=%h want 2004/%h", wr_addr[base_wr+255], wr_data[base_wr+255], mem_f(16'hFFFF)); end
  endtask

  task automatic test_reset_mid();
    cpu_idle_read();
    tick();
    do_trigger(8'h05);
    cpu_idle_read();
    for (int k = 0; k < 2000 && (wr_n - base_wr) < 100; k++) tick();
    checks++;
    if (wr_n - base_wr != 100) begin errors++; $display("FAIL rmid_reach: got %0d writes want 100", wr_n - base_wr); end
    reset_n = 1'b0;
    tick();
    checks++;
    if (rdy !== 1'b1 || dma_busy !== 1'b0)
      begin errors++; $display("FAIL rmid_outputs: rdy=%b busy=%b want 1/0", rdy, dma_busy); end
    reset_n = 1'b1;
    cpu_a = 16'h1234;
    #1;
    checks++;
    if (bus_a !== 16'h1234 || bus_r_w_n !== 1'b1)
      begin errors++; $display("FAIL rmid_passthru: a=%h rw=%b want 1234/1", bus_a, bus_r_w_n); end
    for (int k = 0; k < 600; k++) tick();
    checks++;
    if (wr_n - base_wr != 100 || rdy !== 1'b1)
      begin errors++; $display("FAIL rmid_no_resume: %0d writes rdy=%b want 100/1", wr_n - base_wr, rdy); end
  endtask

  // First-write cycle of the current transfer, taken from the monitor log.
  always @(negedge phi0)
    if (dma_busy === 1'b1 && bus_r_w_n === 1'b0 && cpu_r_w_n === 1'b1 && wr_n == base_wr)
      first_wr_req <= cyc;

  initial begin
    test_reset();
    test_transfer();
    test_halt_writes();
    test_align();
    test_page_ff();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
